// File: rtl/abr_ctrl_pkg.sv
// Shared types and limits for the ML-DSA SRAM arbiter.
// Holds the arbiter FSM state encoding and the requester-count ceiling,
// which also fixes the width of requester ids passed between sub-blocks.
package abr_ctrl_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_ZERO = 1'b1
  } abr_arb_state_e;

  localparam int ABR_ARB_MAX_REQ = 8;
  localparam int ABR_ARB_ID_W    = $clog2(ABR_ARB_MAX_REQ);

endpackage

// File: rtl/abr_rr_arb.sv
// Round-robin arbiter with a per-requester lock, used once per SRAM port.
// Ports: clk/rst_b, req/lock per requester, flush (reset pointer + lock);
//        gnt one-hot, gnt_id, gnt_vld -- all combinational from req this cycle.
module abr_rr_arb
  import abr_ctrl_pkg::*;
#(
  parameter int N = 3
) (
  input  logic                    clk,
  input  logic                    rst_b,
  input  logic [N-1:0]            req,
  input  logic [N-1:0]            lock,
  input  logic                    flush,
  output logic [N-1:0]            gnt,
  output logic [ABR_ARB_ID_W-1:0] gnt_id,
  output logic                    gnt_vld
);

  localparam int                ID_W    = ABR_ARB_ID_W;
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(N - 1);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] own_q, own_d;
  logic            own_vld_q, own_vld_d;

  logic            own_hit;
  logic            hi_vld, lo_vld;
  logic [ID_W-1:0] hi_id, lo_id;
  logic            lock_sel;

  // Scanning downwards leaves the lowest requester at or above the pointer
  // in hi_id and the lowest requester overall in lo_id (the wrap-around pick).
  always_comb begin
    own_hit = 1'b0;
    hi_vld  = 1'b0;
    lo_vld  = 1'b0;
    hi_id   = '0;
    lo_id   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        lo_vld = 1'b1;
        lo_id  = ID_W'(k);
        if (ID_W'(k) >= ptr_q) begin
          hi_vld = 1'b1;
          hi_id  = ID_W'(k);
        end
      end
      if (own_vld_q && (own_q == ID_W'(k)) && req[k]) begin
        own_hit = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_vld   = own_hit | hi_vld | lo_vld;
    gnt_id    = own_hit ? own_q : (hi_vld ? hi_id : lo_id);
    gnt       = '0;
    lock_sel  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (gnt_vld && (gnt_id == ID_W'(k))) begin
        gnt[k]   = 1'b1;
        lock_sel = lock[k];
      end
    end

    ptr_d     = ptr_q;
    own_d     = own_q;
    own_vld_d = 1'b0;   // a lock only survives by being re-asserted on a grant
    if (flush) begin
      ptr_d = '0;
      own_d = '0;
    end else if (gnt_vld) begin
      // A locked owner's pointer already sits just past it, so hold it.
      if (!own_hit) begin
        ptr_d = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
      end
      own_vld_d = lock_sel;
      own_d     = gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ptr_q     <= '0;
      own_q     <= '0;
      own_vld_q <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      own_q     <= own_d;
      own_vld_q <= own_vld_d;
    end
  end

endmodule

// File: rtl/abr_sram_arb.sv
// Shares one 1R/1W SRAM among NUM_REQ requesters, with a zeroize sweep.
// Ports: req_* in / req_ready_o grant, rsp_* read return RD_LAT after grant,
//        sram_* to the macro, zeroize in, zero_busy_o / zero_done_o status.
module abr_sram_arb
  import abr_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 64,
  parameter int RD_LAT  = 1
) (
  input  logic                      clk,
  input  logic                      rst_b,
  input  logic                      zeroize,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ-1:0]        req_we_i,
  input  logic [NUM_REQ-1:0]        req_lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      sram_we_o,
  output logic [ADDR_W-1:0]         sram_waddr_o,
  output logic [DATA_W-1:0]         sram_wdata_o,
  output logic                      sram_re_o,
  output logic [ADDR_W-1:0]         sram_raddr_o,
  input  logic [DATA_W-1:0]         sram_rdata_i,
  output logic                      zero_busy_o,
  output logic                      zero_done_o
);

  localparam int                ID_W      = ABR_ARB_ID_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  abr_arb_state_e    state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              busy;

  logic [NUM_REQ-1:0] rd_cand, wr_cand, rd_gnt, wr_gnt;
  logic [ID_W-1:0]    rd_id, wr_id;
  logic               rd_vld, wr_vld;

  logic [RD_LAT-1:0]           pipe_vld_q, pipe_vld_d;
  logic [RD_LAT-1:0][ID_W-1:0] pipe_id_q, pipe_id_d;

  assign busy    = (state_q == ARB_ZERO);
  // The sweep owns both ports; the zeroize cycle itself still arbitrates,
  // its read is dropped by the pipe flush and its write is swept over.
  assign rd_cand = busy ? '0 : (req_valid_i & ~req_we_i);
  assign wr_cand = busy ? '0 : (req_valid_i &  req_we_i);

  abr_rr_arb #(.N(NUM_REQ)) u_rd_arb (
    .clk     (clk),
    .rst_b   (rst_b),
    .req     (rd_cand),
    .lock    (req_lock_i),
    .flush   (zeroize),
    .gnt     (rd_gnt),
    .gnt_id  (rd_id),
    .gnt_vld (rd_vld)
  );

  abr_rr_arb #(.N(NUM_REQ)) u_wr_arb (
    .clk     (clk),
    .rst_b   (rst_b),
    .req     (wr_cand),
    .lock    (req_lock_i),
    .flush   (zeroize),
    .gnt     (wr_gnt),
    .gnt_id  (wr_id),
    .gnt_vld (wr_vld)
  );

  assign req_ready_o = rd_gnt | wr_gnt;
  assign rsp_rdata_o = sram_rdata_i;
  assign zero_busy_o = busy;
  assign zero_done_o = done_q;

  always_comb begin
    sram_re_o    = rd_vld;
    sram_raddr_o = '0;
    sram_we_o    = wr_vld;
    sram_waddr_o = '0;
    sram_wdata_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (rd_vld && (rd_id == ID_W'(k))) begin
        sram_raddr_o = req_addr_i[k*ADDR_W +: ADDR_W];
      end
      if (wr_vld && (wr_id == ID_W'(k))) begin
        sram_waddr_o = req_addr_i[k*ADDR_W +: ADDR_W];
        sram_wdata_o = req_wdata_i[k*DATA_W +: DATA_W];
      end
    end
    if (busy) begin
      sram_we_o    = 1'b1;
      sram_waddr_o = cnt_q;
      sram_wdata_o = '0;
    end
  end

  // Read-id pipe: the requester id rides alongside the SRAM access.
  always_comb begin
    pipe_vld_d    = '0;
    pipe_id_d     = '0;
    pipe_vld_d[0] = rd_vld;
    pipe_id_d[0]  = rd_id;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      pipe_id_d[i]  = pipe_id_q[i-1];
    end
    if (zeroize) begin
      pipe_vld_d = '0;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_valid_o[k] = pipe_vld_q[RD_LAT-1] && (pipe_id_q[RD_LAT-1] == ID_W'(k));
    end
  end

  // Zeroize restarts the sweep from any state; done fires only on a
  // sweep that ran to its last address undisturbed.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (zeroize) begin
      state_d = ARB_ZERO;
      cnt_d   = '0;
    end else if (busy) begin
      if (cnt_q == LAST_ADDR) begin
        state_d = ARB_IDLE;
        cnt_d   = '0;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      pipe_vld_q <= '0;
      pipe_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      pipe_vld_q <= pipe_vld_d;
      pipe_id_q  <= pipe_id_d;
    end
  end

`ifndef SYNTHESIS
  a_rd_onehot: assert property (@(posedge clk) disable iff (!rst_b) $onehot0(rd_gnt));
  a_wr_onehot: assert property (@(posedge clk) disable iff (!rst_b) $onehot0(wr_gnt));
  a_rsp_onehot: assert property (@(posedge clk) disable iff (!rst_b) $onehot0(rsp_valid_o));
  a_zero_quiet: assert property (@(posedge clk) disable iff (!rst_b)
                                 zero_busy_o |-> ((req_ready_o == '0) && !sram_re_o));
`endif

endmodule
